// File: rtl/nano_mem_arbiter_pkg.sv
// Shared constants for the nano_riscv memory arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package nano_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_XLEN       = 32;
  localparam int DEF_STARVE_MAX = 4;

  // Read-return owner encoding, recorded at grant and consumed one cycle later.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

endpackage

// File: rtl/nano_mem_arbiter_if.sv
// Bundles the fetch port, load/store port and RAM port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req/gnt on each requester; RAM side is always ready.
interface nano_mem_arbiter_if import nano_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int XLEN   = DEF_XLEN
) ();

  // Instruction-fetch requester
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [XLEN-1:0]   o_if_rdata;

  // Load/store requester
  logic              i_d_req;
  logic              i_d_we;
  logic [3:0]        i_d_be;
  logic [ADDR_W-1:0] i_d_addr;
  logic [XLEN-1:0]   i_d_wdata;
  logic              o_d_gnt;
  logic              o_d_rvalid;
  logic [XLEN-1:0]   o_d_rdata;

  // Single-port synchronous RAM
  logic              o_mem_en;
  logic              o_mem_we;
  logic [3:0]        o_mem_be;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [XLEN-1:0]   o_mem_wdata;
  logic [XLEN-1:0]   i_mem_rdata;

  // Arbiter view
  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  // Core + RAM view
  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );

endinterface

// File: rtl/nano_mem_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles fetch has been refused.
// Latency: at_max reflects the count registered at the previous edge.
// Backpressure: none; clr wins over inc.
module nano_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(STARVE_MAX + 1);
  localparam logic [W-1:0] MAX = W'(STARVE_MAX);

  logic [W-1:0] cnt;

  // Count refusals, holding at MAX until fetch is granted or drops its request.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX);

endmodule

// File: rtl/nano_mem_arbiter.sv
// Shares one single-port RAM between fetch and load/store, data first with fetch anti-starvation.
// Latency: grant is combinational; read data returns one cycle after the grant.
// Backpressure: a requester holds req until gnt; at most one grant per cycle, no bubbles.
module nano_mem_arbiter import nano_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int XLEN       = DEF_XLEN,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic             i_clk,
  input  logic             i_rst,
  nano_mem_arbiter_if.slave bus
);

  logic              rst_q;
  logic              arb_en;
  logic              at_max;
  logic              if_gnt;
  logic              d_gnt;
  logic [1:0]        owner_q;
  logic [1:0]        owner_d;
  logic              if_rvalid;
  logic              d_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;

  // Remember last cycle's reset so grants stay off for one cycle after release.
  always_ff @(posedge i_clk) begin
    rst_q <= i_rst;
  end

  assign arb_en = ~i_rst & ~rst_q;

  // Data wins a conflict unless fetch has been refused STARVE_MAX cycles in a row.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (arb_en) begin
      if_gnt = bus.i_if_req & (~bus.i_d_req | at_max);
      d_gnt  = bus.i_d_req & ~(bus.i_if_req & at_max);
    end
  end

  nano_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (i_clk),
    .rst    (i_rst),
    .inc    (bus.i_if_req & ~if_gnt),
    .clr    (~bus.i_if_req | if_gnt),
    .at_max (at_max)
  );

  // Steer the granted request onto the RAM port; everything zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = bus.i_if_addr;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = bus.i_d_we;
      mem_be    = bus.i_d_we ? bus.i_d_be : 4'b0000;
      mem_addr  = bus.i_d_addr;
      mem_wdata = bus.i_d_wdata;
    end
  end

  // Who owns the RAM read data arriving next cycle; writes and idle cycles own nothing.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !bus.i_d_we) begin
      owner_d = OWN_D;
    end
  end

  // Owner register; reset drops any return that is in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign if_rvalid = ~i_rst & (owner_q == OWN_IF);
  assign d_rvalid  = ~i_rst & (owner_q == OWN_D);

  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_d_gnt     = d_gnt;
  assign bus.o_if_rvalid = if_rvalid;
  assign bus.o_d_rvalid  = d_rvalid;
  assign bus.o_if_rdata  = if_rvalid ? bus.i_mem_rdata : '0;
  assign bus.o_d_rdata   = d_rvalid  ? bus.i_mem_rdata : '0;
  assign bus.o_mem_en    = mem_en;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_be    = mem_be;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Self-checking bench for nano_mem_arbiter: reference arbitration model plus read-return scoreboard.
// Latency: expects returns one cycle after each read grant.
// Backpressure: stimulus holds each request until the model predicts its grant.
module tb_nano_mem_arbiter;

  localparam int ADDR_W     = 10;
  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic i_clk = 1'b0;
  logic i_rst;

  always #5 i_clk = ~i_clk;

  nano_mem_arbiter_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) bus ();

  nano_mem_arbiter #(.ADDR_W(ADDR_W), .XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [0:1023];
  logic [31:0] if_q [$];
  logic [31:0] d_q [$];
  int          m_starve;
  bit          m_rstq;
  bit          pend_if;
  bit          pend_d;
  bit          last_ifg;
  bit          last_dg;
  logic [31:0] last_if_rdata;
  logic [31:0] last_d_rdata;

  function automatic logic [31:0] init_word(int a);
    case (a)
      'h004:   return 32'h0BAD_0004;
      'h010:   return 32'hDEAD_BEEF;
      'h020:   return 32'hFFFF_FFFF;
      'h100:   return 32'hCAFE_0100;
      default: return 32'h5A00_0000 | 32'(a);
    endcase
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural single-port RAM with one-cycle read latency.
  initial begin
    logic [31:0] ram [0:1023];
    for (int i = 0; i < 1024; i++) ram[i] = init_word(i);
    bus.i_mem_rdata = '0;
    forever begin
      @(posedge i_clk);
      if (bus.o_mem_en) begin
        if (bus.o_mem_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.o_mem_be[b]) ram[bus.o_mem_addr][8*b +: 8] = bus.o_mem_wdata[8*b +: 8];
        end else begin
          bus.i_mem_rdata <= ram[bus.o_mem_addr];
        end
      end
    end
  end

  // One clock: compare at negedge against the model, then advance the model at posedge.
  task automatic step();
    logic en, ifg, dg, ev_if, ev_d;
    logic [31:0] e_if, e_d;
    e_if = '0;
    e_d  = '0;
    @(negedge i_clk);
    en  = !i_rst && !m_rstq;
    ifg = en && bus.i_if_req && (!bus.i_d_req || m_starve == STARVE_MAX);
    dg  = en && bus.i_d_req && !(bus.i_if_req && m_starve == STARVE_MAX);
    check("if_gnt", 64'(bus.o_if_gnt), 64'(ifg));
    check("d_gnt", 64'(bus.o_d_gnt), 64'(dg));

    ev_if = pend_if && !i_rst;
    ev_d  = pend_d && !i_rst;
    if (pend_if && if_q.size() > 0) e_if = if_q.pop_front();
    if (pend_d && d_q.size() > 0)   e_d  = d_q.pop_front();
    check("if_rvalid", 64'(bus.o_if_rvalid), 64'(ev_if));
    check("d_rvalid", 64'(bus.o_d_rvalid), 64'(ev_d));
    check("if_rdata", 64'(bus.o_if_rdata), ev_if ? 64'(e_if) : 64'd0);
    check("d_rdata", 64'(bus.o_d_rdata), ev_d ? 64'(e_d) : 64'd0);
    if (bus.o_if_rvalid) last_if_rdata = bus.o_if_rdata;
    if (bus.o_d_rvalid)  last_d_rdata  = bus.o_d_rdata;

    if (ifg) begin
      check("mem_if", {bus.o_mem_en, bus.o_mem_we, bus.o_mem_be, 22'(bus.o_mem_addr)},
            {1'b1, 1'b0, 4'b0000, 22'(bus.i_if_addr)});
      if_q.push_back(ref_mem[bus.i_if_addr]);
    end else if (dg) begin
      check("mem_d", {bus.o_mem_en, bus.o_mem_we, bus.o_mem_be, 22'(bus.o_mem_addr)},
            {1'b1, bus.i_d_we, (bus.i_d_we ? bus.i_d_be : 4'b0000), 22'(bus.i_d_addr)});
      if (bus.i_d_we) begin
        check("mem_wdata", 64'(bus.o_mem_wdata), 64'(bus.i_d_wdata));
        for (int b = 0; b < 4; b++)
          if (bus.i_d_be[b]) ref_mem[bus.i_d_addr][8*b +: 8] = bus.i_d_wdata[8*b +: 8];
      end else begin
        d_q.push_back(ref_mem[bus.i_d_addr]);
      end
    end else begin
      check("mem_idle", {bus.o_mem_en, bus.o_mem_we, bus.o_mem_be, 10'(bus.o_mem_addr), bus.o_mem_wdata},
            64'd0);
    end
    last_ifg = ifg;
    last_dg  = dg;

    @(posedge i_clk);
    if (i_rst)                           m_starve = 0;
    else if (bus.i_if_req && !ifg)       m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else                                 m_starve = 0;
    m_rstq  = i_rst;
    pend_if = ifg;
    pend_d  = dg && !bus.i_d_we;
    #1;
  endtask

  initial begin
    int     ngnt;
    logic [5:0] gpat;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    m_starve = 0; m_rstq = 0; pend_if = 0; pend_d = 0;
    last_if_rdata = '0; last_d_rdata = '0;
    i_rst = 1'b1;
    bus.i_if_req = 0; bus.i_if_addr = '0;
    bus.i_d_req = 0; bus.i_d_we = 0; bus.i_d_be = '0; bus.i_d_addr = '0; bus.i_d_wdata = '0;

    // Reset, then fetch only (first cycle after release is dead)
    step(); step();
    i_rst = 1'b0;
    bus.i_if_req = 1; bus.i_if_addr = 10'h010;
    step(); step();
    bus.i_if_req = 0;
    step();
    check("t1_data", 64'(last_if_rdata), 64'h0000_0000_DEAD_BEEF);

    // Simultaneous fetch and data read
    bus.i_if_req = 1; bus.i_if_addr = 10'h004;
    bus.i_d_req = 1; bus.i_d_we = 0; bus.i_d_addr = 10'h100;
    step();
    bus.i_d_req = 0;
    step();
    check("t2_d", 64'(last_d_rdata), 64'h0000_0000_CAFE_0100);
    bus.i_if_req = 0;
    step();
    check("t2_if", 64'(last_if_rdata), 64'h0000_0000_0BAD_0004);

    // Starvation: both held, fetch forced through on cycle 4
    bus.i_if_req = 1; bus.i_if_addr = 10'h004;
    bus.i_d_req = 1; bus.i_d_we = 0; bus.i_d_addr = 10'h100;
    gpat = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      gpat[c] = last_ifg;
    end
    check("t3_pattern", 64'(gpat), 64'b01_0000);
    bus.i_if_req = 0; bus.i_d_req = 0;
    step(); step();

    // Partial write then read-back
    bus.i_d_req = 1; bus.i_d_we = 1; bus.i_d_be = 4'b0011;
    bus.i_d_addr = 10'h020; bus.i_d_wdata = 32'h1234_5678;
    step();
    bus.i_d_req = 0; bus.i_d_we = 0;
    step();
    bus.i_d_req = 1; bus.i_d_addr = 10'h020;
    step();
    bus.i_d_req = 0;
    step();
    check("t4_merge", 64'(last_d_rdata), 64'h0000_0000_FFFF_5678);

    // Reset while a fetch read is in flight
    bus.i_if_req = 1; bus.i_if_addr = 10'h010;
    step();
    bus.i_if_req = 0; i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    bus.i_if_req = 1; bus.i_if_addr = 10'h011;
    step(); step();
    bus.i_if_req = 0;
    step();
    check("t5_after", 64'(last_if_rdata), 64'h0000_0000_5A00_0011);

    // Streaming fetch 0..3
    ngnt = 0;
    for (int a = 0; a < 4; a++) begin
      bus.i_if_req = 1; bus.i_if_addr = 10'(a);
      step();
      if (last_ifg) ngnt++;
    end
    bus.i_if_req = 0;
    step();
    check("t6_grants", 64'(ngnt), 64'd4);

    // Random traffic, each request held until the model grants it
    for (int c = 0; c < 400; c++) begin
      if (!bus.i_if_req && $urandom_range(0, 3) != 0) begin
        bus.i_if_req = 1; bus.i_if_addr = 10'($urandom_range(0, 63));
      end
      if (!bus.i_d_req && $urandom_range(0, 2) == 0) begin
        bus.i_d_req = 1; bus.i_d_we = 1'($urandom_range(0, 1));
        bus.i_d_be = 4'($urandom); bus.i_d_addr = 10'($urandom_range(0, 63));
        bus.i_d_wdata = $urandom;
      end
      step();
      if (last_ifg) bus.i_if_req = 0;
      if (last_dg)  bus.i_d_req = 0;
    end
    bus.i_if_req = 0; bus.i_d_req = 0;
    step(); step();
    check("sb_empty", 64'(if_q.size() + d_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
